pipe_stage_chain: RTL and testbench
===================================

Name: pipe_stage_chain

Overview:
- Parametrised elastic pipeline-register chain.
- Successor to the fixed, free-running IF/ID, ID/EX, EX/MEM and MEM/WB register banks in the processor pipeline.
- Adds the following, none of which the current banks have:
  - valid/ready backpressure
  - global stall
  - per-stage flush, for branch squash
  - occupancy reporting
  - a saturating count of squashed entries
- One instance per pipeline segment; the instruction/control bundle is packed into DATA_W.

Parameters:
- DATA_W, 64: payload width per stage, >= 1.
- DEPTH, 4: number of register stages, >= 1. Stage 0 is at the input; stage DEPTH-1 drives the output.
- CNT_W, 16: width of the squash counter, >= 1.

Ports:
- clk  in  1  rising-edge clock.
- reset  in  1  one clock; reset is asynchronous and active-low (0 = reset asserted).
- in_valid  in  1  upstream entry present.
- in_ready  out  1  chain accepts an entry this cycle.
- in_data  in  DATA_W  upstream payload.
- out_valid  out  1  stage DEPTH-1 is presenting an entry.
- out_ready  in  1  downstream accepts.
- out_data  out  DATA_W  payload of stage DEPTH-1.
- stall  in  1  freeze the whole chain.
- flush_mask  in  DEPTH  bit i squashes stage i at the next edge.
- occupancy  out  $clog2(DEPTH+1)  number of valid stages (registered).
- squash_cnt  out  CNT_W  saturating count of valid entries killed by flush.
- squash_clr  in  1  synchronous clear of squash_cnt.

Behaviour:
- Reset (reset=0, asynchronous):
  - all valid bits 0, all stage data 0
  - occupancy 0, squash_cnt 0
  - out_valid 0, out_data 0
  - in_ready follows its combinational equation, so it is 0 while stall=1.
  - Reset asserted mid-transfer drops every entry; nothing is counted as squashed.
- Handshakes:
  - Input transfer: in_valid & in_ready at a rising edge.
  - Output transfer: out_valid & out_ready at a rising edge.
  - Payload must not be sampled when the corresponding valid is low.
- Advance rule, combinational, from the output backwards:
  - adv[DEPTH-1] = valid[DEPTH-1] & out_ready & ~stall
  - adv[i] = valid[i] & (~valid[i+1] | adv[i+1]) & ~stall
- Ready and output equations:
  - in_ready = (~valid[0] | adv[0]) & ~stall
  - out_valid = valid[DEPTH-1] & ~stall
  - out_data = data[DEPTH-1]
- Throughput and latency:
  - One entry per cycle when unstalled.
  - An entry accepted at edge N first appears on out_valid after edge N+DEPTH-1, i.e. DEPTH cycles of register latency counting the capture edge.
  - Bubbles collapse: an empty stage is filled even if downstream is blocked.
- Next state, before flush:
  - Stage i loads from stage i-1 (or from the input for i=0) when that source advances or transfers in.
  - Otherwise it keeps its entry unless the entry itself advances out, in which case valid drops.
  - Data registers load only on a load, never clear otherwise.
- Flush:
  - valid_next[i] &= ~flush_mask[i]. Flush overrides stall and advance.
  - An entry moving into a flushed stage that cycle is dropped. The upstream handshake still completes, and the source stage still empties.
  - An output transfer in the same cycle as flush_mask[DEPTH-1] still completes, because the downstream already took it.
- Squash counter:
  - Increments by popcount of (valid_next_prefl & flush_mask) each edge.
  - Saturates at 2^CNT_W-1, no wrap.
  - squash_clr has priority over the increment in the same cycle: the result is 0.
- occupancy:
  - Registered popcount of the post-flush valid bits.
  - Always <= DEPTH; DEPTH when full, 0 when empty.
- Stall: no state changes except flush and squash_cnt/squash_clr.
- DEPTH=1: the single stage obeys the same equations, with adv[0] using out_ready.

Test Plan:
- Streaming: DEPTH=4, out_ready=1, push 0x10..0x17 on consecutive cycles -> out_data 0x10..0x17 on consecutive cycles, first valid 4 cycles after the first accept; occupancy steady at 4.
- Backpressure: fill with 0xA0..0xA3, out_ready=0 -> in_ready=0, occupancy=4, out_data holds 0xA0. Raise out_ready -> in-order drain, no loss or duplicate.
- Bubble collapse: push 0x1, wait 2 idle cycles, push 0x2 with out_ready=0 -> entries pack into stages 3 and 2, occupancy=2.
- Flush: full chain 0xB0..0xB3 (0xB0 in stage 3), stall=1, flush_mask=4'b0011 for one cycle -> 0xB2 and 0xB3 lost, squash_cnt=2, occupancy=2. Release -> only 0xB0, 0xB1 emerge.
- Saturation and clear: CNT_W=2, squash 5 entries -> squash_cnt=3. Assert squash_clr together with another squash -> squash_cnt=0.
- Async reset: assert reset=0 mid-stream between edges -> out_valid, occupancy and squash_cnt go to 0 immediately. After release, the first output is the first newly pushed entry.

Source files
------------

// File: rtl/pipe_stage_chain.sv
`default_nettype none
// ============================================================================
// pipe_stage_chain : elastic valid/ready pipeline-register chain with global
// stall, per-stage flush, occupancy and saturating squash counter.
// Revision: 1.0
// ============================================================================
module pipe_stage_chain #(
  parameter  int DATA_W = 64,
  parameter  int DEPTH  = 4,
  parameter  int CNT_W  = 16,
  localparam int OCC_W  = $clog2(DEPTH + 1)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  input  logic              stall,
  input  logic [DEPTH-1:0]  flush_mask,
  output logic [OCC_W-1:0]  occupancy,
  output logic [CNT_W-1:0]  squash_cnt,
  input  logic              squash_clr
);

  localparam int SUM_W = ((CNT_W > OCC_W) ? CNT_W : OCC_W) + 1;
  localparam logic [SUM_W-1:0] CNT_MAX = {{(SUM_W-CNT_W){1'b0}}, {CNT_W{1'b1}}};

  logic [DEPTH-1:0]  valid_q, valid_d;
  logic [DATA_W-1:0] data_q [DEPTH];
  logic [DATA_W-1:0] data_d [DEPTH];
  logic [OCC_W-1:0]  occupancy_q, occupancy_d;
  logic [CNT_W-1:0]  squash_cnt_q, squash_cnt_d;

  logic [DEPTH-1:0]  adv;
  logic [DEPTH-1:0]  load;
  logic [DEPTH-1:0]  valid_prefl;
  logic [DEPTH-1:0]  killed;
  logic              room_ahead;
  logic [SUM_W-1:0]  kill_cnt;
  logic [SUM_W-1:0]  cnt_sum;

  always_comb begin
    adv         = '0;
    load        = '0;
    room_ahead  = out_ready;
    occupancy_d = '0;
    kill_cnt    = '0;
    squash_cnt_d = squash_cnt_q;
    for (int i = 0; i < DEPTH; i++) begin
      data_d[i] = data_q[i];
    end

    // Advance ripples from the output stage back towards the input.
    for (int i = DEPTH - 1; i >= 0; i--) begin
      adv[i]     = valid_q[i] & room_ahead & ~stall;
      room_ahead = ~valid_q[i] | adv[i];
    end

    in_ready = (~valid_q[0] | adv[0]) & ~stall;
    load[0]  = in_valid & in_ready;
    if (load[0]) begin
      data_d[0] = in_data;
    end
    for (int i = 1; i < DEPTH; i++) begin
      load[i] = adv[i-1];
      if (load[i]) begin
        data_d[i] = data_q[i-1];
      end
    end

    valid_prefl = load | (valid_q & ~adv);
    valid_d     = valid_prefl & ~flush_mask;
    killed      = valid_prefl & flush_mask;

    for (int i = 0; i < DEPTH; i++) begin
      occupancy_d = occupancy_d + OCC_W'(valid_d[i]);
      kill_cnt    = kill_cnt + SUM_W'(killed[i]);
    end

    cnt_sum = SUM_W'(squash_cnt_q) + kill_cnt;
    if (squash_clr) begin
      squash_cnt_d = '0;
    end else if (cnt_sum > CNT_MAX) begin
      squash_cnt_d = {CNT_W{1'b1}};
    end else begin
      squash_cnt_d = cnt_sum[CNT_W-1:0];
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      valid_q      <= '0;
      occupancy_q  <= '0;
      squash_cnt_q <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        data_q[i] <= '0;
      end
    end else begin
      valid_q      <= valid_d;
      occupancy_q  <= occupancy_d;
      squash_cnt_q <= squash_cnt_d;
      for (int i = 0; i < DEPTH; i++) begin
        data_q[i] <= data_d[i];
      end
    end
  end

  assign out_valid  = valid_q[DEPTH-1] & ~stall;
  assign out_data   = data_q[DEPTH-1];
  assign occupancy  = occupancy_q;
  assign squash_cnt = squash_cnt_q;

endmodule
`default_nettype wire

// File: tb/tb_pipe_stage_chain.sv
`default_nettype none
// ============================================================================
// tb_pipe_stage_chain : directed self-checking bench for pipe_stage_chain.
// Revision: 1.0
// ============================================================================
module tb_pipe_stage_chain;

  localparam int DATA_W = 8;
  localparam int DEPTH  = 4;
  localparam int CNT_W  = 2;
  localparam int OCC_W  = $clog2(DEPTH + 1);

  logic              clk;
  logic              reset;
  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] in_data;
  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] out_data;
  logic              stall;
  logic [DEPTH-1:0]  flush_mask;
  logic [OCC_W-1:0]  occupancy;
  logic [CNT_W-1:0]  squash_cnt;
  logic              squash_clr;

  int checks = 0;
  int errors = 0;

  pipe_stage_chain #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH),
    .CNT_W  (CNT_W)
  ) u_dut (
    .clk        (clk),
    .reset      (reset),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_data    (in_data),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_data   (out_data),
    .stall      (stall),
    .flush_mask (flush_mask),
    .occupancy  (occupancy),
    .squash_cnt (squash_cnt),
    .squash_clr (squash_clr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset      = 1'b0;
    in_valid   = 1'b0;
    in_data    = '0;
    out_ready  = 1'b0;
    stall      = 1'b0;
    flush_mask = '0;
    squash_clr = 1'b0;

    // Reset state
    repeat (2) tick();
    check("rst_out_valid", 32'(out_valid), 32'h0);
    check("rst_out_data", 32'(out_data), 32'h0);
    check("rst_occupancy", 32'(occupancy), 32'h0);
    check("rst_squash_cnt", 32'(squash_cnt), 32'h0);
    check("rst_in_ready", 32'(in_ready), 32'h1);
    stall = 1'b1;
    #1;
    check("rst_in_ready_stall", 32'(in_ready), 32'h0);
    stall = 1'b0;
    reset = 1'b1;

    // Streaming: 0x10..0x17 back to back, output valid after the 4th edge
    out_ready = 1'b1;
    for (int cyc = 0; cyc < 12; cyc++) begin
      in_valid = (cyc < 8);
      in_data  = 8'(8'h10 + cyc);
      tick();
      check("stream_valid", 32'(out_valid), (cyc >= 3 && cyc <= 10) ? 32'h1 : 32'h0);
      if (cyc >= 3 && cyc <= 10) begin
        check("stream_data", 32'(out_data), 32'(8'h10 + cyc - 3));
      end
      if (cyc == 5) begin
        check("stream_occ", 32'(occupancy), 32'h4);
        check("stream_in_ready", 32'(in_ready), 32'h1);
      end
    end
    in_valid = 1'b0;

    // Backpressure: fill A0..A3 then hold
    out_ready = 1'b0;
    for (int k = 0; k < 4; k++) begin
      in_valid = 1'b1;
      in_data  = 8'(8'hA0 + k);
      tick();
    end
    in_data = 8'hFF;
    #1;
    check("bp_in_ready", 32'(in_ready), 32'h0);
    check("bp_occ", 32'(occupancy), 32'h4);
    check("bp_out_data", 32'(out_data), 32'hA0);
    tick();
    check("bp_hold_data", 32'(out_data), 32'hA0);
    check("bp_hold_occ", 32'(occupancy), 32'h4);
    in_valid  = 1'b0;
    out_ready = 1'b1;
    #1;
    for (int k = 0; k < 4; k++) begin
      check("bp_drain_valid", 32'(out_valid), 32'h1);
      check("bp_drain_data", 32'(out_data), 32'(8'hA0 + k));
      tick();
    end
    check("bp_empty_valid", 32'(out_valid), 32'h0);
    check("bp_empty_occ", 32'(occupancy), 32'h0);

    // Bubble collapse
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_data   = 8'h01;
    tick();
    in_valid = 1'b0;
    repeat (2) tick();
    in_valid = 1'b1;
    in_data  = 8'h02;
    tick();
    in_valid = 1'b0;
    repeat (3) tick();
    check("bubble_occ", 32'(occupancy), 32'h2);
    check("bubble_out_data", 32'(out_data), 32'h01);
    check("bubble_in_ready", 32'(in_ready), 32'h1);
    out_ready = 1'b1;
    tick();
    check("bubble_second", 32'(out_data), 32'h02);
    check("bubble_second_valid", 32'(out_valid), 32'h1);
    tick();
    check("bubble_empty", 32'(occupancy), 32'h0);

    // Flush under stall: B0..B3, kill stages 0 and 1
    out_ready = 1'b0;
    for (int k = 0; k < 4; k++) begin
      in_valid = 1'b1;
      in_data  = 8'(8'hB0 + k);
      tick();
    end
    in_valid   = 1'b0;
    stall      = 1'b1;
    flush_mask = 4'b0011;
    tick();
    flush_mask = '0;
    check("flush_cnt", 32'(squash_cnt), 32'h2);
    check("flush_occ", 32'(occupancy), 32'h2);
    check("flush_stall_valid", 32'(out_valid), 32'h0);
    stall     = 1'b0;
    out_ready = 1'b1;
    #1;
    check("flush_out0", 32'(out_data), 32'hB0);
    tick();
    check("flush_out1", 32'(out_data), 32'hB1);
    check("flush_out1_valid", 32'(out_valid), 32'h1);
    tick();
    check("flush_drained", 32'(out_valid), 32'h0);

    // Saturation: 2 + 4 squashed clamps at 3
    out_ready = 1'b0;
    for (int k = 0; k < 4; k++) begin
      in_valid = 1'b1;
      in_data  = 8'(8'hC0 + k);
      tick();
    end
    in_valid   = 1'b0;
    flush_mask = 4'b1111;
    tick();
    flush_mask = '0;
    check("sat_cnt", 32'(squash_cnt), 32'h3);
    check("sat_occ", 32'(occupancy), 32'h0);

    // Clear wins over a simultaneous squash; the concurrent input still lands
    in_valid = 1'b1;
    in_data  = 8'hD0;
    tick();
    in_data    = 8'hE0;
    flush_mask = 4'b0010;
    squash_clr = 1'b1;
    tick();
    flush_mask = '0;
    squash_clr = 1'b0;
    in_valid   = 1'b0;
    check("clr_cnt", 32'(squash_cnt), 32'h0);
    check("clr_occ", 32'(occupancy), 32'h1);
    out_ready = 1'b1;
    repeat (3) tick();
    check("clr_survivor", 32'(out_data), 32'hE0);
    tick();
    check("clr_drained", 32'(occupancy), 32'h0);

    // Async reset mid-stream
    in_valid = 1'b1;
    in_data  = 8'h99;
    tick();
    in_valid   = 1'b0;
    flush_mask = 4'b0010;
    tick();
    flush_mask = '0;
    check("ar_pre_cnt", 32'(squash_cnt), 32'h1);
    for (int k = 0; k < 5; k++) begin
      in_valid = 1'b1;
      in_data  = 8'(8'h30 + k);
      tick();
    end
    check("ar_pre_valid", 32'(out_valid), 32'h1);
    check("ar_pre_data", 32'(out_data), 32'h31);
    #2;
    reset = 1'b0;
    #1;
    check("ar_out_valid", 32'(out_valid), 32'h0);
    check("ar_occ", 32'(occupancy), 32'h0);
    check("ar_cnt", 32'(squash_cnt), 32'h0);
    check("ar_out_data", 32'(out_data), 32'h0);
    in_valid = 1'b0;
    #1;
    reset = 1'b1;
    in_valid = 1'b1;
    in_data  = 8'h40;
    tick();
    in_data = 8'h41;
    tick();
    in_valid = 1'b0;
    tick();
    check("ar_not_yet", 32'(out_valid), 32'h0);
    tick();
    check("ar_first_valid", 32'(out_valid), 32'h1);
    check("ar_first_data", 32'(out_data), 32'h40);
    tick();
    check("ar_second_data", 32'(out_data), 32'h41);
    tick();
    check("ar_final_empty", 32'(out_valid), 32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
